d_grf_wport_arb: RTL and testbench

//  Arbitrates the single GRF write port between in-order W-stage writeback (pipe) and
//  the long-latency auxiliary writeback (aux: MDU / late-load completion).

---
 rtl/d_grf_wport_arb_pkg.sv | 7 +
 rtl/d_grf_hold_buf.sv | 30 +++
 rtl/d_grf_wport_arb.sv | 88 ++++++++
 tb/tb_d_grf_wport_arb.sv | 125 ++++++++++++
 4 files changed

// File: rtl/d_grf_wport_arb_pkg.sv
// d_grf_wport_arb_pkg: arbiter FSM encodings and the hard-wired zero register index.
package d_grf_wport_arb_pkg;
  localparam logic [1:0] ARB_IDLE  = 2'd0;
  localparam logic [1:0] ARB_WAIT  = 2'd1;
  localparam logic [1:0] ARB_FORCE = 2'd2;
  localparam logic [4:0] GRF_ZERO  = 5'd0;
endpackage

// File: rtl/d_grf_hold_buf.sv
// d_grf_hold_buf: one-entry valid/addr/data/pc holding register with load and clear.
module d_grf_hold_buf #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [ADDR_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_d,
  input  logic [31:0]       in_pc,
  output logic              v,
  output logic [ADDR_W-1:0] a,
  output logic [DATA_W-1:0] d,
  output logic [31:0]       pc
);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      v  <= 1'b0;
      a  <= '0;
      d  <= '0;
      pc <= '0;
    end else if (load) begin
      v  <= 1'b1;
      a  <= in_a;
      d  <= in_d;
      pc <= in_pc;
    end else if (clear) v <= 1'b0;
endmodule

// File: rtl/d_grf_wport_arb.sv
// d_grf_wport_arb: GRF write-port arbiter, pipe writeback over a held aux write with starvation stall.
// Define GRF_TRACE_EN to print a write/kill trace.
module d_grf_wport_arb
  import d_grf_wport_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pipe_we,
  input  logic [ADDR_W-1:0] pipe_a3,
  input  logic [DATA_W-1:0] pipe_wd,
  input  logic [31:0]       pipe_pc,
  input  logic              aux_valid,
  output logic              aux_ready,
  input  logic [ADDR_W-1:0] aux_a3,
  input  logic [DATA_W-1:0] aux_wd,
  input  logic [31:0]       aux_pc,
  output logic              aux_done,
  output logic              grf_we,
  output logic [ADDR_W-1:0] grf_a3,
  output logic [DATA_W-1:0] grf_wd,
  output logic [31:0]       grf_wpc,
  output logic              fwd_v,
  output logic [ADDR_W-1:0] fwd_a,
  output logic [DATA_W-1:0] fwd_d,
  output logic              stall_req
);
  localparam int CW = $clog2(STARVE_MAX + 1);
  logic [1:0] state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [31:0] hold_pc;
  logic pipe_v, accept, load, drop, kill, drain, clear, pipe_wins;
  d_grf_hold_buf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_hold (
    .clk(clk), .reset(reset), .load(load), .clear(clear),
    .in_a(aux_a3), .in_d(aux_wd), .in_pc(aux_pc),
    .v(fwd_v), .a(fwd_a), .d(fwd_d), .pc(hold_pc)
  );
  assign pipe_v    = pipe_we && pipe_a3 != ADDR_W'(GRF_ZERO);
  assign aux_ready = ~fwd_v;
  assign accept    = aux_valid && aux_ready;
  assign load      = accept && aux_a3 != ADDR_W'(GRF_ZERO);
  assign drop      = accept && aux_a3 == ADDR_W'(GRF_ZERO);
  // A younger pipe write to the held register makes the held data stale.
  assign kill      = pipe_v && fwd_v && pipe_a3 == fwd_a;
  assign drain     = !pipe_v && fwd_v;
  assign clear     = kill || drain;
  assign pipe_wins = pipe_v && fwd_v && !kill;
  assign grf_we    = reset && (pipe_v || fwd_v);
  assign grf_a3    = pipe_v ? pipe_a3 : fwd_a;
  assign grf_wd    = pipe_v ? pipe_wd : fwd_d;
  assign grf_wpc   = pipe_v ? pipe_pc : hold_pc;
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (clear) begin
      state_n = ARB_IDLE;
      cnt_n   = '0;
    end else if (load) begin
      state_n = ARB_WAIT;
      cnt_n   = '0;
    end else if (pipe_wins) begin
      cnt_n   = (cnt == CW'(STARVE_MAX)) ? cnt : cnt + CW'(1);
      state_n = (state == ARB_WAIT && cnt == CW'(STARVE_MAX - 1)) ? ARB_FORCE : state;
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state     <= ARB_IDLE;
      cnt       <= '0;
      stall_req <= 1'b0;
      aux_done  <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      stall_req <= state_n == ARB_FORCE;
      aux_done  <= clear || drop;
    end
`ifdef GRF_TRACE_EN
  always_ff @(posedge clk) begin
    if (grf_we && grf_a3 != ADDR_W'(GRF_ZERO))
      $display("%d@%h: $%d <= %h", $time, grf_wpc, grf_a3, grf_wd);
    if (reset && kill) $display("KILL $%d", pipe_a3);
  end
`endif
endmodule

// File: tb/tb_d_grf_wport_arb.sv
// tb_d_grf_wport_arb: scoreboard bench; expected GRF writes are queued as driven and popped on grf_we.
module tb_d_grf_wport_arb;
  logic clk = 0, reset = 0;
  logic pipe_we = 0, aux_valid = 0;
  logic [4:0] pipe_a3 = 0, aux_a3 = 0;
  logic [31:0] pipe_wd = 0, aux_wd = 0, pipe_pc = 32'h100, aux_pc = 32'h200;
  logic aux_ready, aux_done, grf_we, fwd_v, stall_req;
  logic [4:0] grf_a3, fwd_a;
  logic [31:0] grf_wd, grf_wpc, fwd_d;
  logic [36:0] sb[$];
  logic [36:0] e;
  int total = 0, bad = 0;
  d_grf_wport_arb #(.STARVE_MAX(4), .ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .pipe_we(pipe_we), .pipe_a3(pipe_a3), .pipe_wd(pipe_wd),
    .pipe_pc(pipe_pc), .aux_valid(aux_valid), .aux_ready(aux_ready), .aux_a3(aux_a3),
    .aux_wd(aux_wd), .aux_pc(aux_pc), .aux_done(aux_done), .grf_we(grf_we),
    .grf_a3(grf_a3), .grf_wd(grf_wd), .grf_wpc(grf_wpc), .fwd_v(fwd_v), .fwd_a(fwd_a),
    .fwd_d(fwd_d), .stall_req(stall_req)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk)
    if (grf_we) begin
      if (sb.size() == 0) chk("unexpected_write", {grf_a3, grf_wd}, 37'h0);
      else begin
        e = sb.pop_front();
        chk("grf_write", {grf_a3, grf_wd}, e);
      end
    end
  initial begin
    pipe_we = 1; pipe_a3 = 4; pipe_wd = 32'h99;
    #3;
    chk("rst_grf_we", grf_we, 0);
    chk("rst_fwd_v", fwd_v, 0);
    chk("rst_stall", stall_req, 0);
    chk("rst_done", aux_done, 0);
    tick; tick;
    pipe_we = 0;
    reset = 1;
    pipe_we = 1; pipe_a3 = 8; pipe_wd = 32'h11; sb.push_back({5'd8, 32'h11});
    #3;
    chk("p_we", grf_we, 1); chk("p_a3", grf_a3, 8); chk("p_ready", aux_ready, 1);
    tick;
    pipe_we = 0; aux_valid = 1; aux_a3 = 9; aux_wd = 32'h22;
    #3;
    chk("a_ready0", aux_ready, 1); chk("a_nowrite", grf_we, 0);
    tick;
    aux_valid = 0; sb.push_back({5'd9, 32'h22});
    #3;
    chk("a_fwd_v", fwd_v, 1); chk("a_fwd_a", fwd_a, 9); chk("a_fwd_d", fwd_d, 32'h22);
    chk("a_ready1", aux_ready, 0); chk("a_done0", aux_done, 0);
    tick;
    chk("a_done1", aux_done, 1); chk("a_fwd_clr", fwd_v, 0);
    tick;
    chk("a_done2", aux_done, 0);
    aux_valid = 1; aux_a3 = 9; aux_wd = 32'h33;
    tick;
    aux_valid = 0; pipe_we = 1; pipe_a3 = 3;
    for (int i = 0; i < 4; i++) begin
      pipe_wd = i; sb.push_back({5'd3, 32'(i)});
      #3;
      chk("s_nostall", stall_req, 0);
      tick;
    end
    chk("s_stall", stall_req, 1);
    pipe_wd = 4; sb.push_back({5'd3, 32'h4});
    tick;
    chk("s_force_hold", stall_req, 1); chk("s_fwd", fwd_v, 1);
    pipe_we = 0; sb.push_back({5'd9, 32'h33});
    #3;
    chk("s_drain_a3", grf_a3, 9);
    tick;
    chk("s_unstall", stall_req, 0); chk("s_done", aux_done, 1); chk("s_fwd_clr", fwd_v, 0);
    aux_valid = 1; aux_a3 = 5; aux_wd = 32'hAA;
    tick;
    aux_valid = 0; pipe_we = 1; pipe_a3 = 5; pipe_wd = 32'hBB; sb.push_back({5'd5, 32'hBB});
    #3;
    chk("w_fwd", fwd_v, 1); chk("w_wd", grf_wd, 32'hBB);
    tick;
    pipe_we = 0;
    #3;
    chk("w_fwd_clr", fwd_v, 0); chk("w_done", aux_done, 1); chk("w_nowrite", grf_we, 0);
    tick;
    aux_valid = 1; aux_a3 = 0; aux_wd = 32'h55;
    #3;
    chk("z_ready", aux_ready, 1);
    tick;
    aux_valid = 0;
    #3;
    chk("z_fwd", fwd_v, 0); chk("z_done", aux_done, 1); chk("z_nowrite", grf_we, 0);
    pipe_we = 1; pipe_a3 = 0; pipe_wd = 32'h77;
    #1;
    chk("z_pipe", grf_we, 0);
    tick;
    pipe_we = 0; aux_valid = 1; aux_a3 = 7; aux_wd = 32'h44;
    tick;
    aux_valid = 0; pipe_we = 1; pipe_a3 = 3;
    for (int i = 0; i < 5; i++) begin
      pipe_wd = 32'h50 + i; sb.push_back({5'd3, 32'h50 + 32'(i)});
      tick;
    end
    chk("r_stall_pre", stall_req, 1);
    pipe_we = 0; reset = 0;
    #1;
    chk("r_fwd", fwd_v, 0); chk("r_stall", stall_req, 0); chk("r_we", grf_we, 0);
    tick; tick;
    reset = 1;
    tick; tick;
    chk("r_post_fwd", fwd_v, 0); chk("r_post_we", grf_we, 0); chk("r_post_stall", stall_req, 0);
    tick;
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
